axilite_noc_request: RTL

AXI4-Lite slave that converts read (AR) and write (AW+W) requests into OpenPiton NoC non-cacheable load/store request packets. It is the request-side counterpart of the AXI-Lite response path, which parses the NoC acks back into R/B. It sits between an AXI-Lite master (e.g. a peripheral DMA or the Ara-side bridge) and a NoC router port. It holds one read and one write request, arbitrates between them and serialises one packet at a time onto `NOC_DATA_WIDTH` (64-bit) flits.

---
 rtl/axilite_noc_request.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axilite_noc_request.sv
// rtl/axilite_noc_request.sv - AXI4-Lite AW/W/AR requests to OpenPiton NoC non-cacheable load/store packets
//
// Holds one read (AR) and one write (AW+W) request, arbitrates between them
// and serialises one request packet at a time onto 64-bit NoC flits.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_axi_awaddr/awvalid/awready   write address channel
//   s_axi_wdata/wstrb/wvalid/wready write data channel (strobes are not forwarded)
//   s_axi_araddr/arvalid/arready   read address channel
//   noc_valid_out/noc_data_out     outgoing flit and its valid
//   noc_ready_in                   downstream router ready

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif
`ifndef MSG_DST_CHIPID
`define MSG_DST_CHIPID 63:50
`define MSG_DST_X 49:42
`define MSG_DST_Y 41:34
`define MSG_DST_FBITS 33:30
`define MSG_LENGTH 29:22
`define MSG_TYPE 21:14
`define MSG_MSHRID 13:6
`endif
`ifndef MSG_ADDR_
`define MSG_ADDR_ 63:16
`define MSG_DATA_SIZE_ 15:13
`endif
`ifndef MSG_SRC_CHIPID_
`define MSG_SRC_CHIPID_ 63:50
`define MSG_SRC_X_ 49:42
`define MSG_SRC_Y_ 41:34
`define MSG_SRC_FBITS_ 33:30
`endif
`ifndef MSG_TYPE_NC_LOAD_REQ
`define MSG_TYPE_NC_LOAD_REQ 8'd14
`define MSG_TYPE_NC_STORE_REQ 8'd15
`endif
`ifndef MSG_DATA_SIZE_64B
`define MSG_DATA_SIZE_64B 3'b111
`endif
`ifndef NOC_FBITS_MEM
`define NOC_FBITS_MEM 4'b0010
`endif
`ifndef NOC_FBITS_L2
`define NOC_FBITS_L2 4'b0000
`endif

module axilite_noc_request #(
    parameter int          AXI_LITE_ADDR_WIDTH = 64,
    parameter int          AXI_LITE_DATA_WIDTH = 512,
    parameter logic [2:0]  DATA_SIZE           = `MSG_DATA_SIZE_64B,
    parameter logic [13:0] DST_CHIPID          = 14'd0,
    parameter logic [7:0]  DST_X               = 8'd0,
    parameter logic [7:0]  DST_Y               = 8'd0,
    parameter logic [3:0]  DST_FBITS           = `NOC_FBITS_MEM,
    parameter logic [13:0] SRC_CHIPID          = 14'd0,
    parameter logic [7:0]  SRC_X               = 8'd0,
    parameter logic [7:0]  SRC_Y               = 8'd0,
    parameter logic [3:0]  SRC_FBITS           = `NOC_FBITS_L2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                             s_axi_awvalid,
    output logic                             s_axi_awready,
    input  logic [AXI_LITE_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_LITE_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                             s_axi_wvalid,
    output logic                             s_axi_wready,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                             s_axi_arvalid,
    output logic                             s_axi_arready,
    output logic                             noc_valid_out,
    output logic [`NOC_DATA_WIDTH-1:0]       noc_data_out,
    input  logic                             noc_ready_in
);

    localparam int NOC_W         = `NOC_DATA_WIDTH;
    localparam int PHY_W         = `PHY_ADDR_WIDTH;
    localparam int ADDR_FIELD_W  = 48;
    localparam int PAYLOAD_FLITS = AXI_LITE_DATA_WIDTH / NOC_W;
    localparam int CNT_W         = (PAYLOAD_FLITS > 1) ? $clog2(PAYLOAD_FLITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PAYLOAD_FLITS - 1);
    localparam logic [7:0]       LEN_LOAD  = 8'd2;
    localparam logic [7:0]       LEN_STORE = 8'(2 + PAYLOAD_FLITS);

    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_HDR2 = 3'd3,
        S_DATA = 3'd4
    } state_t;

    state_t                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic                             is_store_q, is_store_d;
    logic                             last_grant_q, last_grant_d;
    logic                             aw_full_q, aw_full_d;
    logic [PHY_W-1:0]                 aw_addr_q, aw_addr_d;
    logic                             w_full_q, w_full_d;
    logic [AXI_LITE_DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [AXI_LITE_DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
    logic                             ar_full_q, ar_full_d;
    logic [PHY_W-1:0]                 ar_addr_q, ar_addr_d;

    logic             wr_elig, rd_elig;
    logic             grant_any, grant_write;
    logic             flit_hs, last_flit;
    logic [PHY_W-1:0] pkt_addr;
    logic [NOC_W-1:0] hdr0, hdr1, hdr2, payload;
    logic             unused_bits;

    // Upper address bits and the write strobes have no place in the packet.
    assign unused_bits = ^{w_strb_q,
                           s_axi_awaddr[AXI_LITE_ADDR_WIDTH-1:PHY_W],
                           s_axi_araddr[AXI_LITE_ADDR_WIDTH-1:PHY_W]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            is_store_q   <= 1'b0;
            last_grant_q <= GRANT_WRITE;
            aw_full_q    <= 1'b0;
            aw_addr_q    <= '0;
            w_full_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            ar_full_q    <= 1'b0;
            ar_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_store_q   <= is_store_d;
            last_grant_q <= last_grant_d;
            aw_full_q    <= aw_full_d;
            aw_addr_q    <= aw_addr_d;
            w_full_q     <= w_full_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            ar_full_q    <= ar_full_d;
            ar_addr_q    <= ar_addr_d;
        end
    end

    // Arbitration: when both requests wait, the side that lost the previous
    // contest wins. Uncontested grants leave the history untouched.
    always_comb begin
        wr_elig     = aw_full_q & w_full_q;
        rd_elig     = ar_full_q;
        grant_any   = (state_q == S_IDLE) & (wr_elig | rd_elig);
        grant_write = wr_elig & (~rd_elig | (last_grant_q == GRANT_READ));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (grant_any) state_d = S_HDR0;
            S_HDR0: if (flit_hs) state_d = S_HDR1;
            S_HDR1: if (flit_hs) state_d = S_HDR2;
            S_HDR2: if (flit_hs) state_d = is_store_q ? S_DATA : S_IDLE;
            S_DATA: if (flit_hs && (cnt_q == CNT_LAST)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Header and payload flit construction
    always_comb begin
        pkt_addr = is_store_q ? aw_addr_q : ar_addr_q;

        hdr0                 = '0;
        hdr0[`MSG_DST_CHIPID] = DST_CHIPID;
        hdr0[`MSG_DST_X]      = DST_X;
        hdr0[`MSG_DST_Y]      = DST_Y;
        hdr0[`MSG_DST_FBITS]  = DST_FBITS;
        hdr0[`MSG_LENGTH]     = is_store_q ? LEN_STORE : LEN_LOAD;
        hdr0[`MSG_TYPE]       = is_store_q ? `MSG_TYPE_NC_STORE_REQ : `MSG_TYPE_NC_LOAD_REQ;
        hdr0[`MSG_MSHRID]     = 8'd0;

        hdr1                 = '0;
        hdr1[`MSG_ADDR_]      = ADDR_FIELD_W'(pkt_addr);
        hdr1[`MSG_DATA_SIZE_] = DATA_SIZE;

        hdr2                  = '0;
        hdr2[`MSG_SRC_CHIPID_] = SRC_CHIPID;
        hdr2[`MSG_SRC_X_]      = SRC_X;
        hdr2[`MSG_SRC_Y_]      = SRC_Y;
        hdr2[`MSG_SRC_FBITS_]  = SRC_FBITS;

        payload = w_data_q[int'(cnt_q)*NOC_W +: NOC_W];
    end

    // Outputs. rst gates valid/data/readies combinationally so the port
    // values are quiet for the whole reset cycle, not only after it.
    always_comb begin
        noc_valid_out = 1'b0;
        noc_data_out  = '0;
        if (!rst) begin
            case (state_q)
                S_HDR0: begin noc_valid_out = 1'b1; noc_data_out = hdr0;    end
                S_HDR1: begin noc_valid_out = 1'b1; noc_data_out = hdr1;    end
                S_HDR2: begin noc_valid_out = 1'b1; noc_data_out = hdr2;    end
                S_DATA: begin noc_valid_out = 1'b1; noc_data_out = payload; end
                default: ;
            endcase
        end
        s_axi_awready = ~aw_full_q & ~rst;
        s_axi_wready  = ~w_full_q & ~rst;
        s_axi_arready = ~ar_full_q & ~rst;
        flit_hs       = noc_valid_out & noc_ready_in;
        last_flit     = flit_hs & (((state_q == S_HDR2) & ~is_store_q) |
                                   ((state_q == S_DATA) & (cnt_q == CNT_LAST)));
    end

    // Buffers, payload counter and grant bookkeeping. A full buffer has its
    // ready low, so release and capture can never coincide on one edge.
    always_comb begin
        aw_full_d    = aw_full_q;
        aw_addr_d    = aw_addr_q;
        w_full_d     = w_full_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        ar_full_d    = ar_full_q;
        ar_addr_d    = ar_addr_q;
        cnt_d        = cnt_q;
        is_store_d   = is_store_q;
        last_grant_d = last_grant_q;

        if (last_flit) begin
            if (is_store_q) begin
                aw_full_d = 1'b0;
                w_full_d  = 1'b0;
            end else begin
                ar_full_d = 1'b0;
            end
        end
        if (s_axi_awvalid & s_axi_awready) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axi_awaddr[PHY_W-1:0];
        end
        if (s_axi_wvalid & s_axi_wready) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end
        if (s_axi_arvalid & s_axi_arready) begin
            ar_full_d = 1'b1;
            ar_addr_d = s_axi_araddr[PHY_W-1:0];
        end

        if (grant_any) begin
            is_store_d = grant_write;
            if (wr_elig & rd_elig) begin
                last_grant_d = grant_write ? GRANT_WRITE : GRANT_READ;
            end
        end

        if ((state_q == S_DATA) & flit_hs) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end else if (state_q != S_DATA) begin
            cnt_d = '0;
        end
    end

endmodule
